// File: rtl/vector_ex_sequencer.sv
// vector_ex_sequencer: execute stage behind the ID/EX segment.
// Scalar ops finish in one edge. Vector ops step through the lanes on a narrow
// datapath while stall holds the front of the pipe, then present one registered result.
// Optional build macro: VEX_LANE_PAIR_EN adds a second datapath so two lanes
// are processed per edge.
// All state changes on the falling clock edge, like the segment registers around it.
module vector_ex_sequencer #(
    parameter int unsigned LANES  = 6,
    parameter int unsigned LANE_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_in,
    input  logic                      VectorOp_in,
    input  logic [1:0]                ALUOp_in,
    input  logic                      ALUSrc2_in,
    input  logic [LANE_W-1:0]         RSS1_in,
    input  logic [LANE_W-1:0]         RSS2_in,
    input  logic [LANES*LANE_W-1:0]   RVS1_in,
    input  logic [LANES*LANE_W-1:0]   RVS2_in,
    input  logic [LANE_W-1:0]         num_in,
    input  logic [3:0]                RD_in,
    input  logic                      RegSWrite_in,
    input  logic                      RegVWrite_in,
    output logic                      stall,
    output logic                      busy,
    output logic                      result_valid,
    output logic                      result_is_vector,
    output logic [LANE_W-1:0]         scalar_result,
    output logic [LANES*LANE_W-1:0]   vector_result,
    output logic [3:0]                RD_out,
    output logic                      RegSWrite_out,
    output logic                      RegVWrite_out
);

    localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned VEC_W = LANES * LANE_W;
`ifdef VEX_LANE_PAIR_EN
    localparam int unsigned STEP = 2;
`else
    localparam int unsigned STEP = 1;
`endif
    // Lane index of the final RUN edge
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - STEP);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   lane_idx_q;
    logic [VEC_W-1:0]   op_a_q;
    logic [VEC_W-1:0]   op_b_q;
    logic [1:0]         alu_op_q;
    logic [3:0]         rd_q;
    logic               regs_we_q;
    logic               regv_we_q;
    logic [VEC_W-1:0]   acc_q;
    logic [VEC_W-1:0]   acc_d;

    // Lane ALU: modulo 2^LANE_W, mul keeps the low half of the unsigned product
    function automatic logic [LANE_W-1:0] alu(input logic [1:0]        op,
                                              input logic [LANE_W-1:0] a,
                                              input logic [LANE_W-1:0] b);
        logic [LANE_W-1:0] r;
        case (op)
            2'b00:   r = a + b;
            2'b01:   r = a - b;
            2'b10:   r = a * b;
            default: r = a ^ b;
        endcase
        return r;
    endfunction

    // Accumulator with the lane(s) addressed by lane_idx replaced by this edge's result
    always_comb begin
        acc_d = acc_q;
        for (int s = 0; s < int'(STEP); s++) begin
            acc_d[(int'(lane_idx_q) + s) * int'(LANE_W) +: LANE_W] =
                alu(alu_op_q,
                    op_a_q[(int'(lane_idx_q) + s) * int'(LANE_W) +: LANE_W],
                    op_b_q[(int'(lane_idx_q) + s) * int'(LANE_W) +: LANE_W]);
        end
    end

    // Hold the front of the pipe while a vector op is being accepted or is running
    always_comb begin
        stall = 1'b0;
        if (!rst) begin
            stall = (state_q == StRun) | (valid_in & VectorOp_in);
        end
    end

    // Sequencer FSM with registered result outputs
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= StIdle;
            lane_idx_q       <= '0;
            op_a_q           <= '0;
            op_b_q           <= '0;
            alu_op_q         <= '0;
            rd_q             <= '0;
            regs_we_q        <= 1'b0;
            regv_we_q        <= 1'b0;
            acc_q            <= '0;
            busy             <= 1'b0;
            result_valid     <= 1'b0;
            result_is_vector <= 1'b0;
            scalar_result    <= '0;
            vector_result    <= '0;
            RD_out           <= '0;
            RegSWrite_out    <= 1'b0;
            RegVWrite_out    <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    state_q <= StIdle;
                    if (valid_in && VectorOp_in) begin
                        op_a_q     <= RVS1_in;
                        op_b_q     <= ALUSrc2_in ? {LANES{num_in}} : RVS2_in;
                        alu_op_q   <= ALUOp_in;
                        rd_q       <= RD_in;
                        regs_we_q  <= RegSWrite_in;
                        regv_we_q  <= RegVWrite_in;
                        lane_idx_q <= '0;
                        busy       <= 1'b1;
                        state_q    <= StRun;
                    end else if (valid_in) begin
                        scalar_result    <= alu(ALUOp_in, RSS1_in,
                                                ALUSrc2_in ? num_in : RSS2_in);
                        RD_out           <= RD_in;
                        RegSWrite_out    <= RegSWrite_in;
                        RegVWrite_out    <= RegVWrite_in;
                        result_is_vector <= 1'b0;
                        result_valid     <= 1'b1;
                    end
                end
                StRun: begin
                    acc_q      <= acc_d;
                    lane_idx_q <= lane_idx_q + IDX_W'(STEP);
                    if (lane_idx_q == LAST_IDX) begin
                        // acc_d already holds the final lane, so the result is ready now
                        vector_result    <= acc_d;
                        RD_out           <= rd_q;
                        RegSWrite_out    <= regs_we_q;
                        RegVWrite_out    <= regv_we_q;
                        result_is_vector <= 1'b1;
                        result_valid     <= 1'b1;
                        busy             <= 1'b0;
                        state_q          <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/vector_ex_sequencer.md
# vector_ex_sequencer

Execute-stage consumer of the ID/EX pipeline segment. Takes the decoded operation and operands presented by the ID/EX register and produces scalar results in one cycle. A 192-bit vector operation is processed lane by lane through one 32-bit datapath. While a vector operation is in flight, the block back-pressures the front of the pipeline with `stall` and then presents a registered result with destination and write-enable tags for the EX/MEM segment.

## Interface
Parameters:
- `LANES`, 6, number of vector lanes; must be even.
- `LANE_W`, 32, lane and scalar width.

Ports:
- `clk`  in  1  pipeline clock; all state updates on negedge, matching the segment registers.
- `rst`  in  1  reset, asynchronous, active-high.
- `valid_in`  in  1  ID/EX carries a live instruction this cycle.
- `VectorOp_in`  in  1  1 = vector op, 0 = scalar op.
- `ALUOp_in`  in  2  00 add, 01 sub, 10 mul (low LANE_W bits), 11 xor.
- `ALUSrc2_in`  in  1  operand B select: 0 = register operand, 1 = `num_in` (broadcast to every lane).
- `RSS1_in`, `RSS2_in`  in  32  scalar operands A and B.
- `RVS1_in`, `RVS2_in`  in  192  vector operands A and B; lane i = bits [i*32 +: 32].
- `num_in`  in  32  immediate.
- `RD_in`  in  4  destination register.
- `RegSWrite_in`, `RegVWrite_in`  in  1  write enables to forward.
- `stall`  out  1  combinational; hold the IF/ID and ID/EX segments.
- `busy`  out  1  registered; a vector op is in RUN.
- `result_valid`  out  1  one-cycle pulse; result outputs are meaningful.
- `result_is_vector`  out  1  qualifies which result bus is updated.
- `scalar_result`  out  32  scalar result.
- `vector_result`  out  192  vector result.
- `RD_out`, `RegSWrite_out`, `RegVWrite_out`  out  4/1/1  tags latched at acceptance.

## Operation
- FSM states: IDLE, RUN, DONE. `lane_idx` counter is ceil(log2(LANES)) bits.
- Acceptance: `valid_in` is sampled only in IDLE or DONE; DONE accepts exactly as IDLE does.
- Scalar accept (`VectorOp_in`=0): compute A op B from `RSS1_in` and the selected B.
  - Register `scalar_result`, the tags, `result_is_vector`=0, and `result_valid`=1.
  - State goes to or stays at IDLE. No stall.
- Vector accept: latch A, B (or broadcast `num_in`), ALUOp, and tags into operand registers.
  - Clear `lane_idx`; go to RUN.
- RUN, each edge: write lane `lane_idx` of the accumulator with A[lane] op B[lane], then increment `lane_idx`.
  - After lane LANES-1 is written, go to DONE.
- DONE: copy the accumulator to `vector_result`, set `result_is_vector`=1, and pulse `result_valid`.
- `result_valid` is low in every other state. The result bus not being updated holds its previous value.
- `stall` = (state==RUN) | (state in {IDLE,DONE} & `valid_in` & `VectorOp_in`).
- Arithmetic is modulo 2^32 per lane with no carry between lanes. mul keeps the low 32 bits of the unsigned product. Overflow is not flagged.
- Reset, including mid-RUN: the operation is aborted and state goes to IDLE.
  - All outputs are 0 and `stall` reads 0.
  - The accumulator, operand registers and `lane_idx` are 0.

## Timing
- Scalar op: accepted at edge N; result registered at N, visible for the cycle N..N+1.
- Vector op, full latency:
  - Accepted at edge N.
  - Lanes 0..5 are written at edges N+1..N+6, and the state becomes DONE at N+6.
  - Result is visible for cycle N+6..N+7.
- Stall and busy windows:
  - `stall` is high in the accept cycle plus the 6 RUN cycles (7 cycles), and low in DONE.
  - `busy` is high N..N+6.
- Back-to-back: a vector op presented during DONE is accepted at the edge that ends DONE, so there is no bubble. A scalar op accepted at that edge overwrites `scalar_result` only.
- `valid_in`=0 at acceptance: no state change and no pulse.

## Configuration
- `VEX_LANE_PAIR_EN` defined:
  - Two datapaths; RUN writes lanes `lane_idx` and `lane_idx`+1 per edge and `lane_idx` steps by 2.
  - A vector op spends LANES/2 = 3 cycles in RUN; the result is visible at N+3..N+4 and `stall` lasts 4 cycles.
- Undefined: a single datapath and the 6-cycle RUN described above.

## Test plan
- Reset: assert `rst` mid-RUN at lane 3 -> `stall`, `busy` and `result_valid` drop to 0 immediately. After release, a new scalar op completes normally.
- Scalar add: RSS1=0xFFFFFFFF, RSS2=2, ALUOp=00, RD=5, RegSWrite=1 -> next cycle `scalar_result`=0x00000001, `RD_out`=5, one-cycle `result_valid`, `stall` never high.
- Vector sub with immediate:
  - Stimulus: lanes of RVS1 = {0,1,2,3,4,5}, ALUSrc2=1, num=1, ALUOp=01.
  - Response: lanes {0xFFFFFFFF,0,1,2,3,4}, `result_is_vector`=1, `stall` exactly 7 cycles (4 with `VEX_LANE_PAIR_EN`).
- Vector mul: lane A=0x10000, B=0x10000 -> lane result 0, with no carry into the neighbouring lane. Xor of equal operands -> all-zero 192-bit result.
- Back-to-back: a vector op, then a second vector op held on `valid_in` -> the second is accepted at the DONE edge and two `result_valid` pulses are 7 cycles apart.
- A `valid_in` pulse during RUN is ignored; the in-flight result is unchanged.
